// File: rtl/trap_pkg.sv
// Shared constants and types for the machine-mode trap controller.
// Holds CSR addresses, cause codes, CSR operation encodings and the sequencer states.
package trap_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int CAUSE_ILLEGAL  = 2;
    localparam int CAUSE_ECALL    = 11;
    localparam int CAUSE_IRQ_BASE = 16;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRAP,
        ST_REDIR,
        ST_RET
    } trap_state_e;

endpackage

// File: rtl/trap_ctrl_if.sv
// WB-stage control bundle between the pipeline and the trap sequencer.
// The pipeline drives the master side; trap_ctrl sits on the slave side.
interface trap_ctrl_if #(
    parameter int XLEN    = 32,
    parameter int NUM_IRQ = 4
);
    logic                inst_valid;
    logic [XLEN-1:0]     pc_wb;
    logic [31:0]         inst_wb;
    logic [1:0]          exp_vector;
    logic                mret;
    logic [NUM_IRQ-1:0]  irq;
    logic                csr_rw;
    logic [1:0]          csr_op;
    logic [11:0]         csr_addr;
    logic [XLEN-1:0]     csr_wdata;
    logic [XLEN-1:0]     csr_rdata;
    logic                flush;
    logic                stall;
    logic                redirect;
    logic [XLEN-1:0]     redirect_pc;

    modport master (
        output inst_valid, pc_wb, inst_wb, exp_vector, mret, irq,
               csr_rw, csr_op, csr_addr, csr_wdata,
        input  csr_rdata, flush, stall, redirect, redirect_pc
    );

    modport slave (
        input  inst_valid, pc_wb, inst_wb, exp_vector, mret, irq,
               csr_rw, csr_op, csr_addr, csr_wdata,
        output csr_rdata, flush, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/trap_ctrl_irq_prio_enc.sv
// Lowest-index-wins priority encoder for the enabled interrupt lines.
module irq_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        // Scanning downwards lets the lowest set index overwrite any higher one.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IDX_W'(i);
        end
    end
endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: owns the trap CSRs and drives flush/stall/redirect.
// Optional feature macro TRAP_VECTORED_EN enables vectored mtvec mode for interrupts.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              NUM_IRQ     = 4,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    trap_ctrl_if.slave bus
);
    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
`ifdef TRAP_VECTORED_EN
    localparam logic [XLEN-1:0] MTVEC_WMASK = '1;
`else
    localparam logic [XLEN-1:0] MTVEC_WMASK = ~XLEN'(3);
`endif

    trap_state_e        state_q, state_d;
    logic               mstatus_mie_q, mstatus_mie_d;
    logic               mstatus_mpie_q, mstatus_mpie_d;
    logic [NUM_IRQ-1:0] mie_q, mie_d;
    logic [XLEN-1:0]    mtvec_q, mtvec_d;
    logic [XLEN-1:0]    mepc_q, mepc_d;
    logic [XLEN-1:0]    mcause_q, mcause_d;
    logic [XLEN-1:0]    mtval_q, mtval_d;
    logic [XLEN-1:0]    cap_pc_q, cap_pc_d;
    logic [XLEN-1:0]    cap_cause_q, cap_cause_d;
    logic [XLEN-1:0]    cap_tval_q, cap_tval_d;

    logic               irq_valid;
    logic [IDX_W-1:0]   irq_idx;

    irq_prio_enc #(.N(NUM_IRQ), .IDX_W(IDX_W)) u_prio (
        .req_i   (bus.irq & mie_q),
        .valid_o (irq_valid),
        .idx_o   (irq_idx)
    );

    logic in_idle, ev_illegal, ev_ecall, ev_exc, ev_mret, ev_irq;
    logic take_trap, take_mret, csr_we;

    assign in_idle    = (state_q == ST_IDLE);
    assign ev_illegal = bus.inst_valid & bus.exp_vector[1];
    assign ev_ecall   = bus.inst_valid & bus.exp_vector[0];
    assign ev_exc     = ev_illegal | ev_ecall;
    assign ev_mret    = bus.inst_valid & bus.mret & ~ev_exc;
    assign ev_irq     = bus.inst_valid & ~bus.mret & ~ev_exc & mstatus_mie_q & irq_valid;
    assign take_trap  = in_idle & (ev_exc | ev_irq);
    assign take_mret  = in_idle & ev_mret;
    assign csr_we     = in_idle & bus.inst_valid & bus.csr_rw & ~take_trap & ~take_mret;

    logic [XLEN-1:0] trap_cause;
    always_comb begin
        if (ev_illegal)    trap_cause = XLEN'(CAUSE_ILLEGAL);
        else if (ev_ecall) trap_cause = XLEN'(CAUSE_ECALL);
        else               trap_cause = {1'b1, ((XLEN-1)'(CAUSE_IRQ_BASE) + (XLEN-1)'(irq_idx))};
    end

    logic [XLEN-1:0] csr_old, csr_new;
    always_comb begin
        csr_old = '0;
        case (bus.csr_addr)
            CSR_MSTATUS: begin
                csr_old[MSTATUS_MIE_BIT]  = mstatus_mie_q;
                csr_old[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
            end
            CSR_MIE:    csr_old[CAUSE_IRQ_BASE +: NUM_IRQ] = mie_q;
            CSR_MTVEC:  csr_old = mtvec_q;
            CSR_MEPC:   csr_old = mepc_q;
            CSR_MCAUSE: csr_old = mcause_q;
            CSR_MTVAL:  csr_old = mtval_q;
            CSR_MIP:    csr_old[CAUSE_IRQ_BASE +: NUM_IRQ] = bus.irq;
            default:    ;
        endcase
    end

    always_comb begin
        case (csr_op_e'(bus.csr_op))
            CSR_OP_WRITE: csr_new = bus.csr_wdata;
            CSR_OP_SET:   csr_new = csr_old | bus.csr_wdata;
            CSR_OP_CLEAR: csr_new = csr_old & ~bus.csr_wdata;
            default:      csr_new = csr_old;
        endcase
    end

    logic [XLEN-1:0] trap_target;
    always_comb begin
        trap_target = {mtvec_q[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
        if (mtvec_q[1:0] == 2'b01 && mcause_q[XLEN-1])
            trap_target = trap_target + {mcause_q[XLEN-3:0], 2'b00};
`endif
    end

    logic            flush_c, stall_c, redir_c;
    logic [XLEN-1:0] redir_pc_c;
    always_comb begin
        state_d    = state_q;
        flush_c    = 1'b0;
        stall_c    = 1'b0;
        redir_c    = 1'b0;
        redir_pc_c = '0;
        case (state_q)
            ST_IDLE: begin
                if (take_trap || take_mret) begin
                    state_d = take_trap ? ST_TRAP : ST_RET;
                    flush_c = 1'b1;
                    stall_c = 1'b1;
                end
            end
            ST_TRAP: begin
                stall_c = 1'b1;
                state_d = ST_REDIR;
            end
            ST_REDIR: begin
                redir_c    = 1'b1;
                redir_pc_c = trap_target;
                state_d    = ST_IDLE;
            end
            ST_RET: begin
                redir_c    = 1'b1;
                redir_pc_c = mepc_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are forced low while reset is held, even mid-sequence.
    assign bus.flush       = rst_n & flush_c;
    assign bus.stall       = rst_n & stall_c;
    assign bus.redirect    = rst_n & redir_c;
    assign bus.redirect_pc = rst_n ? redir_pc_c : '0;
    assign bus.csr_rdata   = rst_n ? csr_old : '0;

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        cap_pc_d       = cap_pc_q;
        cap_cause_d    = cap_cause_q;
        cap_tval_d     = cap_tval_q;

        // The trapping instruction is captured at the event so the pipeline may move on.
        if (take_trap) begin
            cap_pc_d    = bus.pc_wb;
            cap_cause_d = trap_cause;
            cap_tval_d  = ev_illegal ? XLEN'(bus.inst_wb) : '0;
        end

        if (csr_we) begin
            case (bus.csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = csr_new[MSTATUS_MIE_BIT];
                    mstatus_mpie_d = csr_new[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:    mie_d    = csr_new[CAUSE_IRQ_BASE +: NUM_IRQ];
                CSR_MTVEC:  mtvec_d  = csr_new & MTVEC_WMASK;
                CSR_MEPC:   mepc_d   = csr_new & ~XLEN'(1);
                CSR_MCAUSE: mcause_d = csr_new;
                CSR_MTVAL:  mtval_d  = csr_new;
                default:    ;
            endcase
        end

        if (state_q == ST_TRAP) begin
            mepc_d         = cap_pc_q & ~XLEN'(1);
            mcause_d       = cap_cause_q;
            mtval_d        = cap_tval_q;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end

        if (state_q == ST_RET) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= MTVEC_RESET & MTVEC_WMASK;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            cap_pc_q       <= '0;
            cap_cause_q    <= '0;
            cap_tval_q     <= '0;
        end else begin
            state_q        <= state_d;
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            cap_pc_q       <= cap_pc_d;
            cap_cause_q    <= cap_cause_d;
            cap_tval_q     <= cap_tval_d;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: a transaction-level model scored every cycle
// plus directed scenarios with literal expectations.
module tb_trap_ctrl;

`ifdef TRAP_VECTORED_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    trap_ctrl_if #(.XLEN(32), .NUM_IRQ(4)) bus ();

    trap_ctrl #(.XLEN(32), .NUM_IRQ(4), .MTVEC_RESET(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural model of the CSR file and of the pending redirect sequence.
    bit          m_mie_en, m_mpie;
    logic [31:0] m_mie, m_mtvec, m_mepc, m_mcause, m_mtval;

    typedef struct packed {
        logic        stall;
        logic        redir;
        logic [31:0] pc;
    } slot_t;
    slot_t pend[$];

    task automatic m_reset();
        m_mie_en = 1'b0; m_mpie = 1'b0;
        m_mie = '0; m_mtvec = '0; m_mepc = '0; m_mcause = '0; m_mtval = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return {24'h0, m_mpie, 3'b000, m_mie_en, 3'b000};
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return {12'h0, bus.irq, 16'h0};
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_write(input logic [11:0] a, input logic [1:0] op, input logic [31:0] w);
        logic [31:0] nv;
        case (op)
            2'b01:   nv = w;
            2'b10:   nv = m_read(a) | w;
            2'b11:   nv = m_read(a) & ~w;
            default: nv = m_read(a);
        endcase
        case (a)
            12'h300: begin m_mie_en = nv[3]; m_mpie = nv[7]; end
            12'h304: m_mie = nv & 32'h000F_0000;
            12'h305: m_mtvec = VEC ? nv : (nv & ~32'h3);
            12'h341: m_mepc = nv & ~32'h1;
            12'h342: m_mcause = nv;
            12'h343: m_mtval = nv;
            default: ;
        endcase
    endtask

    always @(negedge clk) begin : scoreboard
        slot_t       s;
        logic [31:0] pend_irq, tgt;
        bit          exc, take_irq, go_trap, go_mret;
        int          code;
        if (!rst_n) begin
            check("rst_flush", 32'(bus.flush), 32'h0);
            check("rst_stall", 32'(bus.stall), 32'h0);
            check("rst_redirect", 32'(bus.redirect), 32'h0);
            check("rst_rdata", bus.csr_rdata, 32'h0);
            m_reset();
            pend.delete();
        end else if (pend.size() > 0) begin
            s = pend.pop_front();
            check("seq_flush", 32'(bus.flush), 32'h0);
            check("seq_stall", 32'(bus.stall), 32'(s.stall));
            check("seq_redirect", 32'(bus.redirect), 32'(s.redir));
            if (s.redir) check("seq_redirect_pc", bus.redirect_pc, s.pc);
        end else begin
            exc      = bus.inst_valid && (bus.exp_vector != 2'b00);
            go_mret  = bus.inst_valid && bus.mret && !exc;
            pend_irq = {28'h0, bus.irq} & (m_mie >> 16);
            take_irq = bus.inst_valid && !bus.mret && !exc && m_mie_en && (pend_irq != 0);
            go_trap  = exc || take_irq;
            check("idle_flush", 32'(bus.flush), 32'(go_trap || go_mret));
            check("idle_stall", 32'(bus.stall), 32'(go_trap || go_mret));
            check("idle_redirect", 32'(bus.redirect), 32'h0);
            check("idle_rdata", bus.csr_rdata, m_read(bus.csr_addr));
            if (go_trap) begin
                m_mepc  = bus.pc_wb & ~32'h1;
                m_mtval = 32'h0;
                if (bus.exp_vector[1]) begin
                    m_mcause = 32'd2;
                    m_mtval  = bus.inst_wb;
                end else if (bus.exp_vector[0]) begin
                    m_mcause = 32'd11;
                end else begin
                    code = 0;
                    for (int k = 3; k >= 0; k--) if (pend_irq[k]) code = k;
                    m_mcause = 32'h8000_0000 | 32'(16 + code);
                end
                m_mpie   = m_mie_en;
                m_mie_en = 1'b0;
                tgt = m_mtvec & ~32'h3;
                if (VEC && m_mtvec[1:0] == 2'b01 && m_mcause[31])
                    tgt = tgt + 4 * (m_mcause & 32'h7FFF_FFFF);
                s.stall = 1'b1; s.redir = 1'b0; s.pc = 32'h0;
                pend.push_back(s);
                s.stall = 1'b0; s.redir = 1'b1; s.pc = tgt;
                pend.push_back(s);
            end else if (go_mret) begin
                s.stall = 1'b0; s.redir = 1'b1; s.pc = m_mepc;
                pend.push_back(s);
                m_mie_en = m_mpie;
                m_mpie   = 1'b1;
            end else if (bus.inst_valid && bus.csr_rw) begin
                m_write(bus.csr_addr, bus.csr_op, bus.csr_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.inst_valid = 1'b0; bus.pc_wb = '0; bus.inst_wb = '0; bus.exp_vector = 2'b00;
        bus.mret = 1'b0; bus.csr_rw = 1'b0; bus.csr_op = 2'b00; bus.csr_addr = '0; bus.csr_wdata = '0;
    endtask

    task automatic csr_instr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        bus.inst_valid = 1'b1; bus.csr_rw = 1'b1; bus.csr_op = op; bus.csr_addr = a; bus.csr_wdata = d;
        tick();
        clear_in();
    endtask

    task automatic read_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
        bus.csr_addr = a;
        #1;
        check(name, bus.csr_rdata, exp);
        tick();
    endtask

    // Event at cycle T: flush at T, then stall at T+1 and redirect at T+2 (MRET: redirect at T+1).
    task automatic take_event(input string name, input logic [31:0] pc, input logic [31:0] inst,
                              input logic [1:0] ev, input logic is_mret, input logic [31:0] tgt);
        bus.inst_valid = 1'b1; bus.pc_wb = pc; bus.inst_wb = inst;
        bus.exp_vector = ev; bus.mret = is_mret;
        #1;
        check({name, "_flush"}, 32'(bus.flush), 32'h1);
        tick();
        clear_in();
        if (!is_mret) begin
            #1;
            check({name, "_hold"}, 32'({bus.stall, bus.redirect}), 32'h2);
            tick();
        end
        #1;
        check({name, "_redirect"}, 32'(bus.redirect), 32'h1);
        check({name, "_target"}, bus.redirect_pc, tgt);
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int nflush, nred;
        clear_in();
        bus.irq = 4'b0000;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", 32'({bus.flush, bus.stall, bus.redirect}), 32'h0);
        rst_n = 1'b1;
        read_chk("rst_mtvec", 12'h305, 32'h0);
        read_chk("rst_mstatus", 12'h300, 32'h0);
        read_chk("rst_mcause", 12'h342, 32'h0);

        // Illegal instruction
        csr_instr(2'b01, 12'h305, 32'h0000_0100);
        read_chk("mtvec_wr", 12'h305, 32'h0000_0100);
        take_event("illegal", 32'h40, 32'hFFFF_FFFF, 2'b10, 1'b0, 32'h100);
        read_chk("ill_mepc", 12'h341, 32'h40);
        read_chk("ill_mcause", 12'h342, 32'h2);
        read_chk("ill_mtval", 12'h343, 32'hFFFF_FFFF);

        // CSR boundaries: unmapped address, read-only mip, mepc bit 0
        read_chk("unmapped", 12'h345, 32'h0);
        csr_instr(2'b01, 12'h344, 32'hFFFF_FFFF);
        read_chk("mip_ro", 12'h344, 32'h0);
        csr_instr(2'b01, 12'h341, 32'h0000_0123);
        read_chk("mepc_lsb", 12'h341, 32'h0000_0122);

        // ECALL then MRET
        csr_instr(2'b10, 12'h300, 32'h8);
        read_chk("mie_set", 12'h300, 32'h8);
        take_event("ecall", 32'h80, 32'h0000_0073, 2'b01, 1'b0, 32'h100);
        read_chk("ecall_mcause", 12'h342, 32'd11);
        read_chk("ecall_mstatus", 12'h300, 32'h80);
        read_chk("ecall_mtval", 12'h343, 32'h0);
        take_event("mret", 32'h200, 32'h3020_0073, 2'b00, 1'b1, 32'h80);
        read_chk("mret_mstatus", 12'h300, 32'h88);

        // Interrupt priority with enable masking
        csr_instr(2'b01, 12'h305, 32'h0000_0201);
        read_chk("mtvec_mode", 12'h305, VEC ? 32'h201 : 32'h200);
        csr_instr(2'b01, 12'h304, 32'hFFFA_FFFF);
        read_chk("mie_field", 12'h304, 32'h000A_0000);
        bus.irq = 4'b1010;
        read_chk("mip_view", 12'h344, 32'h000A_0000);
        take_event("irq17", 32'h300, 32'h13, 2'b00, 1'b0, VEC ? 32'h244 : 32'h200);
        bus.irq = 4'b0000;
        read_chk("irq17_mcause", 12'h342, 32'h8000_0011);
        read_chk("irq17_mstatus", 12'h300, 32'h80);

        // Masking: MIE clear, then mie bit 16 clear
        csr_instr(2'b01, 12'h304, 32'h0001_0000);
        bus.irq = 4'b0001;
        nflush = 0;
        for (int k = 0; k < 10; k++) begin
            bus.inst_valid = 1'b1; bus.pc_wb = 32'h1000 + 32'(4 * k);
            #1;
            nflush += int'(bus.flush);
            tick();
        end
        clear_in();
        csr_instr(2'b11, 12'h304, 32'h0001_0000);
        csr_instr(2'b10, 12'h300, 32'h8);
        for (int k = 0; k < 10; k++) begin
            bus.inst_valid = 1'b1; bus.pc_wb = 32'h1100 + 32'(4 * k);
            #1;
            nflush += int'(bus.flush);
            tick();
        end
        clear_in();
        check("mask_noflush", 32'(nflush), 32'h0);
        csr_instr(2'b10, 12'h304, 32'h0001_0000);
        take_event("irq16", 32'h2000, 32'h13, 2'b00, 1'b0, VEC ? 32'h240 : 32'h200);
        bus.irq = 4'b0000;
        read_chk("irq16_mcause", 12'h342, 32'h8000_0010);

        // CSR write to mtvec in the same cycle as an illegal instruction
        bus.csr_rw = 1'b1; bus.csr_op = 2'b01; bus.csr_addr = 12'h305; bus.csr_wdata = 32'h400;
        take_event("simul", 32'h500, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h200);
        read_chk("simul_mtvec", 12'h305, VEC ? 32'h201 : 32'h200);
        read_chk("simul_mcause", 12'h342, 32'h2);
        read_chk("simul_mtval", 12'h343, 32'hDEAD_BEEF);

        // Reset asserted while in TRAP
        bus.inst_valid = 1'b1; bus.pc_wb = 32'h600; bus.exp_vector = 2'b01;
        #1;
        check("midrst_flush", 32'(bus.flush), 32'h1);
        tick();
        clear_in();
        rst_n = 1'b0;
        nred = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            nred += int'(bus.redirect);
            tick();
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            nred += int'(bus.redirect);
            tick();
        end
        check("midrst_noredirect", 32'(nred), 32'h0);
        read_chk("midrst_mtvec", 12'h305, 32'h0);
        read_chk("midrst_mepc", 12'h341, 32'h0);
        read_chk("midrst_mcause", 12'h342, 32'h0);
        read_chk("midrst_mtval", 12'h343, 32'h0);
        read_chk("midrst_mstatus", 12'h300, 32'h0);
        read_chk("midrst_mie", 12'h304, 32'h0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
